cache_controller_dm: RTL and testbench
======================================

// Module: cache_controller_dm
// PURPOSE
// - Direct-mapped, write-through, write-allocate cache controller with its own backing store.
// - Sits between a processor-side request port and a private 256-byte main memory.
// - Serves one byte read/write per request and reports hit/miss per lookup.
// PARAMETERS
// - ADDR_W       8  byte address width; main memory holds 2**ADDR_W bytes
// - DATA_W       8  data width; one byte per cache line
// - INDEX_W      3  index bits; 2**INDEX_W = 8 cache lines; tag = ADDR_W-INDEX_W = 5 bits
// - MEM_LATENCY  2  cycles spent in FILL on a read miss (>=1)
// PORTS
// - CC_clk          in   1       single clock; all state updates on rising edge
// - rst             in   1       synchronous, active-high reset
// - start           in   1       request enable; sampled only in IDLE
// - read_operation  in   1       1 = read, 0 = write; latched with start
// - address         in   ADDR_W  byte address; latched with start
// - write_data      in   DATA_W  write byte; latched with start
// - read_data       out  DATA_W  registered read result
// - hit             out  1       registered; lookup hit
// - miss            out  1       registered; lookup miss
// BEHAVIOUR
// - Address split: index = address[INDEX_W-1:0], tag = address[ADDR_W-1:INDEX_W].
// - Per line: valid bit, tag, data byte.
// - Reset:
//   - read_data=0, hit=0, miss=0, state=IDLE.
//   - All valid bits cleared; all main-memory bytes cleared to 0.
//   - Reset wins over everything and aborts any operation in flight.
// - FSM states: IDLE, COMPARE, FILL, DONE.
// - IDLE:
//   - start=1: latch address, read_operation and write_data; go to COMPARE.
//   - start=0: stay in IDLE.
// - COMPARE (1 cycle): a line is a hit when valid && tag match.
//   - hit <= match, miss <= ~match; exactly one of the two is set.
//   - Read hit: read_data <= line data; go to DONE.
//   - Read miss: go to FILL.
//   - Write, hit or miss:
//     - Memory gets the byte.
//     - Line gets the byte, the new tag and valid=1 (allocate, evicting the old line).
//     - Go to DONE.
// - FILL: wait MEM_LATENCY cycles, then:
//   - Line <= memory byte, tag updated, valid=1.
//   - read_data <= memory byte.
//   - Go to DONE.
// - DONE (1 cycle): go to IDLE.
// - Latency (default MEM_LATENCY=2):
//   - Hit or write: 3 cycles start-to-IDLE.
//   - Read miss: 5 cycles.
// - If start is held high, requests reissue back to back.
//   - Inputs may change every 5 cycles.
// - Hold rules:
//   - hit and miss hold until the next COMPARE.
//   - read_data changes only on a read hit or on FILL completion.
//   - Writes never change read_data.
// - Input changes outside IDLE are ignored until the next IDLE sample.
// - Eviction needs no write-back, because memory is always current (write-through).
// TESTING
// - Reset: rst=1 for 5 cycles -> read_data=0, hit=0, miss=0.
//   - A read of any address then misses and returns 0.
// - Write addr 0 <- 5 after reset -> first lookup miss=1.
//   - Write addr 0 <- 15 -> hit=1; line 0 holds 15.
// - Write addr 1 <- 15 -> miss=1 on first issue, hit=1 on reissue.
//   - Line 0 unaffected.
// - Read addr 0 -> hit=1, read_data=15 in COMPARE cycle.
//   - Read addr 15 (index 7, tag 1) -> miss=1; read_data=0 after FILL.
// - Conflict: write addr 8 <- 20 evicts line 0.
//   - Read addr 0 -> miss=1, read_data=15 (from memory).
//   - Read addr 8 -> miss=1, read_data=20.
// - Assert rst during FILL -> next cycle IDLE, outputs 0, all lines invalid.

Source files
------------

// File: rtl/cache_controller_dm_if.sv
// Processor-side request/response bundle for the direct-mapped cache controller.
// The requester drives start/read_operation/address/write_data; the cache answers with read_data/hit/miss.
interface cache_controller_dm_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              start;
    logic              read_operation;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic              hit;
    logic              miss;

    modport master (
        output start,
        output read_operation,
        output address,
        output write_data,
        input  read_data,
        input  hit,
        input  miss
    );

    modport slave (
        input  start,
        input  read_operation,
        input  address,
        input  write_data,
        output read_data,
        output hit,
        output miss
    );
endinterface

// File: rtl/cache_controller_dm.sv
// Direct-mapped, write-through, write-allocate byte cache with a private backing memory.
// One request is served per IDLE->COMPARE->(FILL)->DONE pass; memory is always current, so eviction is free.
module cache_controller_dm #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int INDEX_W     = 3,
    parameter int MEM_LATENCY = 2
) (
    input  logic                   CC_clk,
    input  logic                   rst,
    cache_controller_dm_if.slave   bus
);
    localparam int TAG_W   = ADDR_W - INDEX_W;
    localparam int LINES   = 2 ** INDEX_W;
    localparam int MEM_SZ  = 2 ** ADDR_W;
    localparam int CNT_W   = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        FILL,
        DONE
    } state_t;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_read_op;
    logic [DATA_W-1:0]  r_wdata;
    logic [DATA_W-1:0]  r_read_data;
    logic               r_hit;
    logic               r_miss;
    logic [CNT_W-1:0]   r_cnt;
    logic [LINES-1:0]   r_valid;
    logic [TAG_W-1:0]   r_tag  [LINES];
    logic [DATA_W-1:0]  r_line [LINES];
    logic [DATA_W-1:0]  r_mem  [MEM_SZ];

    logic [INDEX_W-1:0] w_index;
    logic [TAG_W-1:0]   w_tag;
    logic               w_match;

    assign w_index = r_addr[INDEX_W-1:0];
    assign w_tag   = r_addr[ADDR_W-1:INDEX_W];
    assign w_match = r_valid[w_index] && (r_tag[w_index] == w_tag);

    assign bus.read_data = r_read_data;
    assign bus.hit       = r_hit;
    assign bus.miss      = r_miss;

    always_ff @(posedge CC_clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_read_op   <= 1'b0;
            r_wdata     <= '0;
            r_read_data <= '0;
            r_hit       <= 1'b0;
            r_miss      <= 1'b0;
            r_cnt       <= '0;
            r_valid     <= '0;
            for (int i = 0; i < MEM_SZ; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_addr    <= bus.address;
                        r_read_op <= bus.read_operation;
                        r_wdata   <= bus.write_data;
                        r_state   <= COMPARE;
                    end
                end
                COMPARE: begin
                    r_hit  <= w_match;
                    r_miss <= ~w_match;
                    r_cnt  <= '0;
                    if (r_read_op) begin
                        if (w_match) begin
                            r_read_data <= r_line[w_index];
                            r_state     <= DONE;
                        end else begin
                            r_state <= FILL;
                        end
                    end else begin
                        // Write-through with allocate: memory and line both take the byte.
                        r_mem[r_addr]     <= r_wdata;
                        r_line[w_index]   <= r_wdata;
                        r_tag[w_index]    <= w_tag;
                        r_valid[w_index]  <= 1'b1;
                        r_state           <= DONE;
                    end
                end
                FILL: begin
                    if (r_cnt == CNT_W'(MEM_LATENCY - 1)) begin
                        r_line[w_index]  <= r_mem[r_addr];
                        r_tag[w_index]   <= w_tag;
                        r_valid[w_index] <= 1'b1;
                        r_read_data      <= r_mem[r_addr];
                        r_state          <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cache_controller_dm.sv
// Directed self-checking bench for cache_controller_dm with hand-computed hit/miss and data expectations.
module tb_cache_controller_dm;
    logic CC_clk;
    logic rst;
    int   errCount;
    int   checkCount;

    cache_controller_dm_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    cache_controller_dm #(
        .ADDR_W(8), .DATA_W(8), .INDEX_W(3), .MEM_LATENCY(2)
    ) dut (
        .CC_clk (CC_clk),
        .rst    (rst),
        .bus    (bus)
    );

    initial CC_clk = 1'b0;
    always #5 CC_clk = ~CC_clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkResult(input string tag, input logic expHit, input logic expMiss,
                               input logic [7:0] expData);
        checkOutput({tag, ".hit"},  {31'd0, bus.hit},  {31'd0, expHit});
        checkOutput({tag, ".miss"}, {31'd0, bus.miss}, {31'd0, expMiss});
        checkOutput({tag, ".data"}, {24'd0, bus.read_data}, {24'd0, expData});
    endtask

    // Issue one request, scramble the inputs after the IDLE sample, then idle long enough for any path.
    task automatic applyStimulus(input logic rd, input logic [7:0] addr, input logic [7:0] wdata);
        @(negedge CC_clk);
        bus.start          = 1'b1;
        bus.read_operation = rd;
        bus.address        = addr;
        bus.write_data     = wdata;
        @(posedge CC_clk);
        @(negedge CC_clk);
        bus.start          = 1'b0;
        bus.read_operation = ~rd;
        bus.address        = ~addr;
        bus.write_data     = 8'($urandom_range(0, 255));
        repeat (6) @(posedge CC_clk);
        #1;
    endtask

    initial begin
        errCount           = 0;
        checkCount         = 0;
        rst                = 1'b1;
        bus.start          = 1'b0;
        bus.read_operation = 1'b0;
        bus.address        = '0;
        bus.write_data     = '0;
        repeat (5) @(posedge CC_clk);
        #1;
        checkResult("reset", 1'b0, 1'b0, 8'd0);
        @(negedge CC_clk);
        rst = 1'b0;

        applyStimulus(1'b1, 8'h23, 8'h00);
        checkResult("rdAfterReset", 1'b0, 1'b1, 8'd0);

        applyStimulus(1'b0, 8'h00, 8'd5);
        checkResult("wr0First", 1'b0, 1'b1, 8'd0);

        applyStimulus(1'b0, 8'h00, 8'd15);
        checkResult("wr0Again", 1'b1, 1'b0, 8'd0);

        // Held start: first pass misses on line 1, the reissue hits.
        @(negedge CC_clk);
        bus.start          = 1'b1;
        bus.read_operation = 1'b0;
        bus.address        = 8'h01;
        bus.write_data     = 8'd15;
        repeat (2) @(posedge CC_clk);
        #1;
        checkResult("wr1Issue", 1'b0, 1'b1, 8'd0);
        repeat (3) @(posedge CC_clk);
        #1;
        checkResult("wr1Reissue", 1'b1, 1'b0, 8'd0);
        @(negedge CC_clk);
        bus.start = 1'b0;
        repeat (4) @(posedge CC_clk);

        @(negedge CC_clk);
        bus.start          = 1'b1;
        bus.read_operation = 1'b1;
        bus.address        = 8'h00;
        @(posedge CC_clk);
        @(negedge CC_clk);
        bus.start = 1'b0;
        @(posedge CC_clk);
        #1;
        checkResult("rd0HitCompare", 1'b1, 1'b0, 8'd15);
        repeat (4) @(posedge CC_clk);

        @(negedge CC_clk);
        bus.start          = 1'b1;
        bus.read_operation = 1'b1;
        bus.address        = 8'h0F;
        @(posedge CC_clk);
        @(negedge CC_clk);
        bus.start   = 1'b0;
        bus.address = 8'hAA;
        repeat (2) @(posedge CC_clk);
        #1;
        checkResult("rd15MidFill", 1'b0, 1'b1, 8'd15);
        @(posedge CC_clk);
        #1;
        checkOutput("rd15AfterFill.data", {24'd0, bus.read_data}, 32'd0);
        repeat (4) @(posedge CC_clk);

        applyStimulus(1'b0, 8'h08, 8'd20);
        checkResult("wr8Evict", 1'b0, 1'b1, 8'd0);

        applyStimulus(1'b1, 8'h00, 8'h00);
        checkResult("rd0FromMem", 1'b0, 1'b1, 8'd15);

        applyStimulus(1'b1, 8'h08, 8'h00);
        checkResult("rd8FromMem", 1'b0, 1'b1, 8'd20);

        applyStimulus(1'b1, 8'h08, 8'h00);
        checkResult("rd8Hit", 1'b1, 1'b0, 8'd20);

        applyStimulus(1'b1, 8'h01, 8'h00);
        checkResult("rd1Hit", 1'b1, 1'b0, 8'd15);

        // Reset lands while a read miss is filling.
        @(negedge CC_clk);
        bus.start          = 1'b1;
        bus.read_operation = 1'b1;
        bus.address        = 8'h40;
        @(posedge CC_clk);
        @(negedge CC_clk);
        bus.start = 1'b0;
        @(posedge CC_clk);
        @(negedge CC_clk);
        rst = 1'b1;
        @(posedge CC_clk);
        #1;
        checkResult("rstInFill", 1'b0, 1'b0, 8'd0);
        @(negedge CC_clk);
        rst = 1'b0;

        applyStimulus(1'b1, 8'h01, 8'h00);
        checkResult("rd1AfterRst", 1'b0, 1'b1, 8'd0);

        applyStimulus(1'b1, 8'h08, 8'h00);
        checkResult("rd8AfterRst", 1'b0, 1'b1, 8'd0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end
endmodule
